// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared encodings and constants for the RV32M divide sequencer
package div_pkg;

    localparam int DIV_W = 32;

    // funct3[1:0]: bit0 = unsigned, bit1 = remainder
    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    // Most negative signed value at the default width
    localparam logic [DIV_W-1:0] MIN_INT = {1'b1, {(DIV_W-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } div_state_e;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one radix-2 restoring division iteration
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   p_i,
    input  logic [WIDTH-1:0] q_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH:0]   p_o,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH:0]   p_sh;
    logic [WIDTH+1:0] trial;

    // Shift the next dividend bit into P, try the subtraction, restore on borrow
    always_comb begin
        p_sh  = {p_i[WIDTH-1:0], q_i[WIDTH-1]};
        trial = {1'b0, p_sh} - {2'b00, b_i};
        if (!trial[WIDTH+1]) begin
            p_o = trial[WIDTH:0];
            q_o = {q_i[WIDTH-2:0], 1'b1};
        end else begin
            p_o = p_sh;
            q_o = {q_i[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/div_seq_ctrl.sv
// rtl/div_seq_ctrl.sv - multi-cycle DIV/DIVU/REM/REMU sequencer with sign fixup
module div_seq_ctrl
    import div_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic [TAG_W-1:0] req_tag,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_result,
    output logic [TAG_W-1:0] resp_tag,
    output logic             busy
);

    localparam int              CW      = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] MIN_W   = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CW-1:0]    CNT_END = CW'(WIDTH - 1);

    div_state_e       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH:0]   p_q, p_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             rem_q, rem_d;
    logic             negq_q, negq_d;
    logic             negr_q, negr_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [WIDTH-1:0] result_q, result_d;

    logic [WIDTH:0]   step_p;
    logic [WIDTH-1:0] step_q;

    logic             op_signed;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic             div_zero, sgn_ovf;

    div_step #(.WIDTH(WIDTH)) u_step (
        .p_i (p_q),
        .q_i (q_q),
        .b_i (b_q),
        .p_o (step_p),
        .q_o (step_q)
    );

    // Operand decode: magnitudes and the two special cases that skip the iteration
    always_comb begin
        op_signed = ~req_op[0];
        a_neg     = op_signed & req_a[WIDTH-1];
        b_neg     = op_signed & req_b[WIDTH-1];
        a_mag     = a_neg ? (~req_a + ONE) : req_a;
        b_mag     = b_neg ? (~req_b + ONE) : req_b;
        div_zero  = (req_b == '0);
        sgn_ovf   = op_signed && (req_a == MIN_W) && (req_b == '1);
    end

    // Next-state and datapath: accept, iterate, fix sign, hold until taken
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        p_d      = p_q;
        q_d      = q_q;
        b_d      = b_q;
        rem_d    = rem_q;
        negq_d   = negq_q;
        negr_d   = negr_q;
        tag_d    = tag_q;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid && !flush) begin
                    tag_d  = req_tag;
                    rem_d  = req_op[1];
                    negq_d = a_neg ^ b_neg;
                    negr_d = a_neg;
                    if (div_zero) begin
                        result_d = req_op[1] ? req_a : '1;
                        state_d  = S_DONE;
                    end else if (sgn_ovf) begin
                        result_d = req_op[1] ? '0 : MIN_W;
                        state_d  = S_DONE;
                    end else begin
                        cnt_d   = '0;
                        p_d     = '0;
                        q_d     = a_mag;
                        b_d     = b_mag;
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                p_d   = step_p;
                q_d   = step_q;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CNT_END) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                if (rem_q) begin
                    result_d = negr_q ? (~p_q[WIDTH-1:0] + ONE) : p_q[WIDTH-1:0];
                end else begin
                    result_d = negq_q ? (~q_q + ONE) : q_q;
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                if (resp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (flush) begin
            state_d = S_IDLE;
        end
    end

    // State and datapath registers; reset aborts any operation
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            p_q      <= '0;
            q_q      <= '0;
            b_q      <= '0;
            rem_q    <= 1'b0;
            negq_q   <= 1'b0;
            negr_q   <= 1'b0;
            tag_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            p_q      <= p_d;
            q_q      <= q_d;
            b_q      <= b_d;
            rem_q    <= rem_d;
            negq_q   <= negq_d;
            negr_q   <= negr_d;
            tag_q    <= tag_d;
            result_q <= result_d;
        end
    end

    assign req_ready   = (state_q == S_IDLE);
    assign busy        = (state_q != S_IDLE);
    assign resp_valid  = (state_q == S_DONE);
    assign resp_result = result_q;
    assign resp_tag    = tag_q;

endmodule

// File: tb/tb_div_seq_ctrl.sv
// tb/tb_div_seq_ctrl.sv - directed self-checking bench for div_seq_ctrl
module tb_div_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [4:0]  req_tag;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_result;
    logic [4:0]  resp_tag;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    div_seq_ctrl #(.WIDTH(32), .TAG_W(5)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_tag     (req_tag),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_result (resp_result),
        .resp_tag    (resp_tag),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one request, wait for resp_valid, check latency/result/tag; leaves it in DONE
    task automatic issue(input string name, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] tag,
                         input logic [31:0] exp_res, input int exp_lat);
        int lat;
        check({name, ".ready_before"}, {31'b0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_tag   = tag;
        tick();
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 100) begin
            tick();
            lat++;
        end
        check({name, ".latency"}, lat, exp_lat);
        check({name, ".result"}, resp_result, exp_res);
        check({name, ".tag"}, {27'b0, resp_tag}, {27'b0, tag});
    endtask

    task automatic drain(input string name);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        check({name, ".idle_after"}, {31'b0, req_ready}, 32'd1);
        check({name, ".valid_after"}, {31'b0, resp_valid}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] held_res;
        logic [4:0]  held_tag;
        rst = 1'b1; flush = 1'b0; req_valid = 1'b0; resp_ready = 1'b0;
        req_op = 2'b00; req_a = '0; req_b = '0; req_tag = '0;
        tick(); tick();
        rst = 1'b0;
        check("rst.ready", {31'b0, req_ready}, 32'd1);
        check("rst.busy", {31'b0, busy}, 32'd0);
        check("rst.valid", {31'b0, resp_valid}, 32'd0);
        check("rst.result", resp_result, 32'd0);
        check("rst.tag", {27'b0, resp_tag}, 32'd0);

        issue("divu_100_7", 2'b01, 32'd100, 32'd7, 5'd3, 32'd14, 34);   drain("divu_100_7");
        issue("remu_100_7", 2'b11, 32'd100, 32'd7, 5'd17, 32'd2, 34);   drain("remu_100_7");
        issue("div_m7_2", 2'b00, 32'hFFFF_FFF9, 32'd2, 5'd5, 32'hFFFF_FFFD, 34); drain("div_m7_2");
        issue("rem_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFF, 34); drain("rem_m7_2");
        issue("rem_7_m2", 2'b10, 32'd7, 32'hFFFF_FFFE, 5'd7, 32'd1, 34);  drain("rem_7_m2");
        issue("div_7_m2", 2'b00, 32'd7, 32'hFFFF_FFFE, 5'd8, 32'hFFFF_FFFD, 34); drain("div_7_m2");
        issue("div_5_0", 2'b00, 32'd5, 32'd0, 5'd9, 32'hFFFF_FFFF, 1);   drain("div_5_0");
        issue("remu_5_0", 2'b11, 32'd5, 32'd0, 5'd10, 32'd5, 1);        drain("remu_5_0");
        issue("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h8000_0000, 1); drain("div_ovf");
        issue("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'd0, 1); drain("rem_ovf");
        issue("divu_big", 2'b01, 32'hFFFF_FFFF, 32'd1, 5'd13, 32'hFFFF_FFFF, 34); drain("divu_big");

        // Flush on the 10th CALC cycle
        req_valid = 1'b1; req_op = 2'b01; req_a = 32'd1000; req_b = 32'd3; req_tag = 5'd20;
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        check("flush.busy_before", {31'b0, busy}, 32'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush.ready", {31'b0, req_ready}, 32'd1);
        check("flush.busy", {31'b0, busy}, 32'd0);
        check("flush.valid", {31'b0, resp_valid}, 32'd0);
        for (int i = 0; i < 30; i++) tick();
        check("flush.valid_late", {31'b0, resp_valid}, 32'd0);
        issue("divu_9_3", 2'b01, 32'd9, 32'd3, 5'd21, 32'd3, 34);       drain("divu_9_3");

        // Hold in DONE with resp_ready low and a competing request
        issue("hold", 2'b01, 32'd1000, 32'd10, 5'd22, 32'd100, 34);
        held_res = resp_result;
        held_tag = resp_tag;
        req_valid = 1'b1; req_op = 2'b01; req_a = 32'd50; req_b = 32'd5; req_tag = 5'd1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold.valid", {31'b0, resp_valid}, 32'd1);
            check("hold.result", resp_result, 32'd100);
            check("hold.tag", {27'b0, resp_tag}, 32'd22);
            check("hold.ready", {31'b0, req_ready}, 32'd0);
        end
        check("hold.result_vs_first", resp_result, held_res);
        check("hold.tag_vs_first", {27'b0, resp_tag}, {27'b0, held_tag});
        req_valid = 1'b0;
        drain("hold");

        // Reset in the middle of CALC
        req_valid = 1'b1; req_op = 2'b00; req_a = 32'd77; req_b = 32'd7; req_tag = 5'd30;
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst.ready", {31'b0, req_ready}, 32'd1);
        check("midrst.busy", {31'b0, busy}, 32'd0);
        check("midrst.valid", {31'b0, resp_valid}, 32'd0);
        check("midrst.result", resp_result, 32'd0);
        check("midrst.tag", {27'b0, resp_tag}, 32'd0);

        // Flush together with req_valid in IDLE
        req_valid = 1'b1; flush = 1'b1; req_op = 2'b01; req_a = 32'd8; req_b = 32'd0; req_tag = 5'd4;
        tick();
        req_valid = 1'b0; flush = 1'b0;
        check("flushacc.busy", {31'b0, busy}, 32'd0);
        check("flushacc.ready", {31'b0, req_ready}, 32'd1);
        tick();
        check("flushacc.valid", {31'b0, resp_valid}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
